// File: rtl/vga_fb_stream_reader.sv
// VGA timing generator with a streaming framebuffer reader: fixed-latency word fetch,
// pixel unpacking and horizontal/vertical replication for the display path.
module vga_fb_stream_reader #(
   parameter int unsigned H_VISIBLE     = 640,
   parameter int unsigned H_FRONT       = 16,
   parameter int unsigned H_SYNC        = 96,
   parameter int unsigned H_BACK        = 48,
   parameter int unsigned V_VISIBLE     = 480,
   parameter int unsigned V_FRONT       = 10,
   parameter int unsigned V_SYNC        = 2,
   parameter int unsigned V_BACK        = 33,
   parameter int unsigned SYNC_POLARITY = 0,
   parameter int unsigned BPP           = 4,
   parameter int unsigned DATA_W        = 4,
   parameter int unsigned H_SCALE       = 2,
   parameter int unsigned V_SCALE       = 1,
   parameter int unsigned RD_LATENCY    = 1
) (
   input  logic              clk,
   input  logic              rst,
   output logic              h_sync_out,
   output logic              v_sync_out,
   output logic              de_out,
   output logic [BPP-1:0]    pixel_out,
   output logic              rd_req,
   input  logic [DATA_W-1:0] rd_data,
   output logic              line_rewind,
   output logic              frame_start
);

   localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
   localparam int unsigned PPW     = DATA_W / BPP;
   localparam int unsigned W       = PPW * H_SCALE;
   localparam int unsigned WPL     = H_VISIBLE / W;
   localparam int unsigned HC_W    = $clog2(H_TOTAL);
   localparam int unsigned VC_W    = $clog2(V_TOTAL);
   localparam int unsigned FW_W    = $clog2(W + 1);
   localparam int unsigned HS_W    = $clog2(H_SCALE + 1);
   localparam int unsigned VS_W    = $clog2(V_SCALE + 1);
   localparam int unsigned F_AHEAD = RD_LATENCY + 1;
   localparam int unsigned F_W0    = F_AHEAD % W;
   localparam logic        SYNC_IDLE = 1'(SYNC_POLARITY == 0);

   // Parameter legality is checked at elaboration time.
   if (!(BPP == 1 || BPP == 2 || BPP == 4 || BPP == 8)) begin : g_bad_bpp
      $error("BPP must be 1, 2, 4 or 8");
   end
   if (DATA_W % BPP != 0 || DATA_W < BPP) begin : g_bad_dw
      $error("DATA_W must be a multiple of BPP");
   end
   if (H_SCALE < 1 || V_SCALE < 1 || RD_LATENCY < 1) begin : g_bad_scale
      $error("H_SCALE, V_SCALE and RD_LATENCY must be >= 1");
   end
   if (WPL * W != H_VISIBLE) begin : g_bad_hvis
      $error("H_VISIBLE must be a multiple of PPW*H_SCALE");
   end
   if (V_VISIBLE % V_SCALE != 0) begin : g_bad_vvis
      $error("V_VISIBLE must be a multiple of V_SCALE");
   end
   if (RD_LATENCY + 1 > H_FRONT + H_SYNC + H_BACK) begin : g_bad_lat
      $error("RD_LATENCY+1 must fit in horizontal blanking");
   end

   logic [HC_W-1:0]       hc, hc_nxt, fhc, fhc_nxt;
   logic [VC_W-1:0]       vc, vc_nxt, fvc, fvc_nxt;
   logic [FW_W-1:0]       fw, fw_nxt;
   logic [VS_W-1:0]       vsc, vsc_nxt;
   logic [HS_W-1:0]       hcnt, hcnt_nxt, phase_c;
   logic [RD_LATENCY:0]   tag;
   logic [DATA_W-1:0]     sr, sr_nxt, base_c;
   logic                  h_act_c, v_act_c, de_c, issue_c, rewind_c, fs_c, load_c;
   logic                  hc_last, fhc_last;
   logic [BPP-1:0]        pix_c;

   assign rd_req = tag[0];

   // Counters, fetch schedule and pixel unpack.  fhc/fvc run RD_LATENCY+1 clocks
   // ahead of hc/vc so a request targets the pixel position its word will fill.
   always_comb begin
      hc_nxt   = hc;
      vc_nxt   = vc;
      fhc_nxt  = fhc;
      fvc_nxt  = fvc;
      fw_nxt   = fw;
      vsc_nxt  = vsc;
      sr_nxt   = sr;
      hcnt_nxt = hcnt;
      hc_last  = (hc == HC_W'(H_TOTAL - 1));
      fhc_last = (fhc == HC_W'(H_TOTAL - 1));

      if (hc_last) begin
         hc_nxt = '0;
         vc_nxt = (vc == VC_W'(V_TOTAL - 1)) ? '0 : vc + VC_W'(1);
         if (vc == VC_W'(V_TOTAL - 1) || vsc == VS_W'(V_SCALE - 1)) vsc_nxt = '0;
         else                                                         vsc_nxt = vsc + VS_W'(1);
      end else begin
         hc_nxt = hc + HC_W'(1);
      end

      if (fhc_last) begin
         fhc_nxt = '0;
         fvc_nxt = (fvc == VC_W'(V_TOTAL - 1)) ? '0 : fvc + VC_W'(1);
         fw_nxt  = '0;
      end else begin
         fhc_nxt = fhc + HC_W'(1);
         fw_nxt  = (fw == FW_W'(W - 1)) ? '0 : fw + FW_W'(1);
      end

      h_act_c  = (hc >= HC_W'(H_VISIBLE + H_FRONT)) &&
                 (hc <= HC_W'(H_VISIBLE + H_FRONT + H_SYNC - 1));
      v_act_c  = (vc >= VC_W'(V_VISIBLE + V_FRONT)) &&
                 (vc <= VC_W'(V_VISIBLE + V_FRONT + V_SYNC - 1));
      de_c     = (hc < HC_W'(H_VISIBLE)) && (vc < VC_W'(V_VISIBLE));
      issue_c  = (fhc < HC_W'(H_VISIBLE)) && (fvc < VC_W'(V_VISIBLE)) && (fw == '0);
      rewind_c = (hc == HC_W'(H_VISIBLE)) && (vc < VC_W'(V_VISIBLE - 1)) &&
                 (vsc != VS_W'(V_SCALE - 1));
      fs_c     = (hc == '0) && (vc == VC_W'(V_TOTAL - 1));

      // A word arriving this cycle is shown immediately and parked in sr.
      load_c  = tag[RD_LATENCY];
      base_c  = load_c ? rd_data : sr;
      phase_c = load_c ? '0 : hcnt;
      pix_c   = base_c[BPP-1:0];
      if (phase_c == HS_W'(H_SCALE - 1)) begin
         sr_nxt   = base_c >> BPP;
         hcnt_nxt = '0;
      end else begin
         sr_nxt   = base_c;
         hcnt_nxt = phase_c + HS_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hc          <= '0;
         vc          <= VC_W'(V_TOTAL - 1);
         fhc         <= HC_W'(F_AHEAD);
         fvc         <= VC_W'(V_TOTAL - 1);
         fw          <= FW_W'(F_W0);
         vsc         <= '0;
         hcnt        <= '0;
         sr          <= '0;
         tag         <= '0;
         h_sync_out  <= SYNC_IDLE;
         v_sync_out  <= SYNC_IDLE;
         de_out      <= 1'b0;
         pixel_out   <= '0;
         line_rewind <= 1'b0;
         frame_start <= 1'b0;
      end else begin
         hc          <= hc_nxt;
         vc          <= vc_nxt;
         fhc         <= fhc_nxt;
         fvc         <= fvc_nxt;
         fw          <= fw_nxt;
         vsc         <= vsc_nxt;
         hcnt        <= hcnt_nxt;
         sr          <= sr_nxt;
         tag         <= {tag[RD_LATENCY-1:0], issue_c};
         h_sync_out  <= h_act_c ^ SYNC_IDLE;
         v_sync_out  <= v_act_c ^ SYNC_IDLE;
         de_out      <= de_c;
         pixel_out   <= de_c ? pix_c : '0;
         line_rewind <= rewind_c;
         frame_start <= fs_c;
      end
   end

endmodule
